psum_drain_requant: RTL and testbench

Sits between the systolic array's column accumulators and the sigmoid activation stage. Captures one row of NUM_COLS wide partial sums plus per-column biases in a single handshake. Serializes the row one column per cycle. For each column it adds the bias, rounds, and saturates to the signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS value z that sigmoid consumes.

---
 rtl/psum_drain_requant_pkg.sv | 19 +
 rtl/psum_drain_requant_if.sv | 36 +++
 rtl/psum_drain_requant_sat.sv | 48 ++++
 rtl/psum_drain_requant.sv | 115 +++++++++++
 tb/tb_psum_drain_requant.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_drain_requant_pkg.sv
// ffn_pkg: constants and FSM state type shared by the requant drain and the
// sigmoid activation stage.
//   FFN_DATA_WIDTH : width of bias / requantized z (signed)
//   FFN_FRAC_BITS  : fraction bits of bias / z (accumulators carry twice this)
//   FFN_ACC_WIDTH  : signed column accumulator width
//   FFN_NUM_COLS   : columns per captured row
package ffn_pkg;

   localparam int FFN_DATA_WIDTH = 16;
   localparam int FFN_FRAC_BITS  = 8;
   localparam int FFN_ACC_WIDTH  = 40;
   localparam int FFN_NUM_COLS   = 4;

   typedef enum logic {
      DRAIN_IDLE = 1'b0,
      DRAIN_BUSY = 1'b1
   } drain_state_e;

endpackage

// File: rtl/psum_drain_requant_if.sv
// Handshake bundle for the accumulator drain / requant block.
//   acc side : acc_valid_i, acc_ready_o, acc_i, bias_i (one full row per beat)
//   z side   : z_o, z_col_o, z_last_o, sat_o, z_valid_o, z_ready_i
// slave is the drain block, master is the row source plus downstream sink.
interface psum_drain_requant_if
   import ffn_pkg::*;
#(
   parameter int DATA_WIDTH = FFN_DATA_WIDTH,
   parameter int ACC_WIDTH  = FFN_ACC_WIDTH,
   parameter int NUM_COLS   = FFN_NUM_COLS
);

   localparam int COL_W = $clog2(NUM_COLS);

   logic                           acc_valid_i;
   logic                           acc_ready_o;
   logic [NUM_COLS*ACC_WIDTH-1:0]  acc_i;
   logic [NUM_COLS*DATA_WIDTH-1:0] bias_i;
   logic [DATA_WIDTH-1:0]          z_o;
   logic [COL_W-1:0]               z_col_o;
   logic                           z_last_o;
   logic                           sat_o;
   logic                           z_valid_o;
   logic                           z_ready_i;

   modport master (
      output acc_valid_i, acc_i, bias_i, z_ready_i,
      input  acc_ready_o, z_o, z_col_o, z_last_o, sat_o, z_valid_o
   );

   modport slave (
      input  acc_valid_i, acc_i, bias_i, z_ready_i,
      output acc_ready_o, z_o, z_col_o, z_last_o, sat_o, z_valid_o
   );

endinterface

// File: rtl/psum_drain_requant_sat.sv
// requant_sat: combinational bias add, round-half-up and saturation.
//   acc  : signed accumulator, 2*FRAC_BITS fraction bits
//   bias : signed bias, FRAC_BITS fraction bits
//   z    : signed result, FRAC_BITS fraction bits, clipped to DATA_WIDTH
//   sat  : z was clipped
module requant_sat
   import ffn_pkg::*;
#(
   parameter int DATA_WIDTH = FFN_DATA_WIDTH,
   parameter int FRAC_BITS  = FFN_FRAC_BITS,
   parameter int ACC_WIDTH  = FFN_ACC_WIDTH
) (
   input  logic signed [ACC_WIDTH-1:0]  acc,
   input  logic signed [DATA_WIDTH-1:0] bias,
   output logic        [DATA_WIDTH-1:0] z,
   output logic                         sat
);

   // Two guard bits: one for the bias add, one for the rounding add.
   localparam int EW = ACC_WIDTH + 2;
   localparam logic signed [EW-1:0] HALF  = EW'(2 ** (FRAC_BITS - 1));
   localparam logic signed [EW-1:0] Z_MAX = EW'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [EW-1:0] Z_MIN = -Z_MAX - EW'(1);

   logic signed [EW-1:0] acc_x;
   logic signed [EW-1:0] bias_x;
   logic signed [EW-1:0] sum;
   logic signed [EW-1:0] rnd;

   assign acc_x  = {{(EW - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
   assign bias_x = {{(EW - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
   assign sum    = acc_x + (bias_x <<< FRAC_BITS);
   // Arithmetic shift floors, so adding half first rounds ties toward +inf.
   assign rnd    = (sum + HALF) >>> FRAC_BITS;

   always_comb begin
      z   = rnd[DATA_WIDTH-1:0];
      sat = 1'b0;
      if (rnd > Z_MAX) begin
         z   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
         sat = 1'b1;
      end else if (rnd < Z_MIN) begin
         z   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/psum_drain_requant.sv
// psum_drain_requant: captures one row of column accumulators plus biases,
// then emits one requantized column per cycle toward the sigmoid stage.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : row capture handshake (acc_*, bias_i) and z output stream
//
// state      | meaning
// DRAIN_IDLE | ready for a row; last z of the previous row may still be held
// DRAIN_BUSY | emitting columns of the captured row, one per accepted beat
module psum_drain_requant
   import ffn_pkg::*;
#(
   parameter int DATA_WIDTH = FFN_DATA_WIDTH,
   parameter int FRAC_BITS  = FFN_FRAC_BITS,
   parameter int ACC_WIDTH  = FFN_ACC_WIDTH,
   parameter int NUM_COLS   = FFN_NUM_COLS
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   psum_drain_requant_if.slave  bus
);

   localparam int COL_W = $clog2(NUM_COLS);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

   drain_state_e                   state;
   logic [NUM_COLS*ACC_WIDTH-1:0]  acc_q;
   logic [NUM_COLS*DATA_WIDTH-1:0] bias_q;
   logic [COL_W-1:0]               col;

   logic                           acc_ready_q;
   logic [DATA_WIDTH-1:0]          z_q;
   logic [COL_W-1:0]               z_col_q;
   logic                           z_last_q;
   logic                           sat_q;
   logic                           z_valid_q;

   logic signed [ACC_WIDTH-1:0]    acc_sel;
   logic signed [DATA_WIDTH-1:0]   bias_sel;
   logic [DATA_WIDTH-1:0]          z_next;
   logic                           sat_next;
   logic                           load;

   assign acc_sel  = acc_q[col*ACC_WIDTH +: ACC_WIDTH];
   assign bias_sel = bias_q[col*DATA_WIDTH +: DATA_WIDTH];

   requant_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_requant_sat (
      .acc  (acc_sel),
      .bias (bias_sel),
      .z    (z_next),
      .sat  (sat_next)
   );

   // Output register is free when empty or being consumed this cycle.
   assign load = !z_valid_q || bus.z_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= DRAIN_IDLE;
         acc_q       <= '0;
         bias_q      <= '0;
         col         <= '0;
         acc_ready_q <= 1'b1;
         z_q         <= '0;
         z_col_q     <= '0;
         z_last_q    <= 1'b0;
         sat_q       <= 1'b0;
         z_valid_q   <= 1'b0;
      end else begin
         case (state)
            DRAIN_IDLE: begin
               if (z_valid_q && bus.z_ready_i) z_valid_q <= 1'b0;
               if (bus.acc_valid_i) begin
                  acc_q       <= bus.acc_i;
                  bias_q      <= bus.bias_i;
                  col         <= '0;
                  acc_ready_q <= 1'b0;
                  state       <= DRAIN_BUSY;
               end
            end
            DRAIN_BUSY: begin
               if (load) begin
                  z_q       <= z_next;
                  z_col_q   <= col;
                  z_last_q  <= (col == LAST_COL);
                  sat_q     <= sat_next;
                  z_valid_q <= 1'b1;
                  if (col == LAST_COL) begin
                     col         <= '0;
                     acc_ready_q <= 1'b1;
                     state       <= DRAIN_IDLE;
                  end else begin
                     col <= col + COL_W'(1);
                  end
               end
            end
            default: begin
               state       <= DRAIN_IDLE;
               acc_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.acc_ready_o = acc_ready_q;
   assign bus.z_o         = z_q;
   assign bus.z_col_o     = z_col_q;
   assign bus.z_last_o    = z_last_q;
   assign bus.sat_o       = sat_q;
   assign bus.z_valid_o   = z_valid_q;

endmodule

// File: tb/tb_psum_drain_requant.sv
module tb_psum_drain_requant;

   localparam int DW = 16;
   localparam int FB = 8;
   localparam int AW = 40;
   localparam int NC = 4;

   typedef struct packed {
      logic [DW-1:0] z;
      logic [1:0]    col;
      logic          last;
      logic          sat;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_errors;

   exp_t              q[$];
   longint            acc_v[NC];
   logic signed [15:0] bias_v[NC];

   psum_drain_requant_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_COLS(NC)) bus ();

   psum_drain_requant #(
      .DATA_WIDTH (DW),
      .FRAC_BITS  (FB),
      .ACC_WIDTH  (AW),
      .NUM_COLS   (NC)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: bias add, round half toward +inf via floor division, clip.
   function automatic exp_t model(input longint a, input logic signed [15:0] b, input int c);
      exp_t   e;
      longint s, t, r;
      s = a + longint'(b) * 256;
      t = s + 128;
      r = t / 256;
      if (t < 0 && (t % 256) != 0) r = r - 1;
      e.col  = 2'(c);
      e.last = (c == NC - 1);
      if (r > 32767) begin
         e.z = 16'h7FFF; e.sat = 1'b1;
      end else if (r < -32768) begin
         e.z = 16'h8000; e.sat = 1'b1;
      end else begin
         e.z = 16'(r); e.sat = 1'b0;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents the current acc_v/bias_v row and holds valid until captured.
   task automatic send_row(output int acc_cyc);
      logic was_ready;
      bit   done;
      for (int i = 0; i < NC; i++) begin
         bus.acc_i[i*AW +: AW]  = acc_v[i][AW-1:0];
         bus.bias_i[i*DW +: DW] = bias_v[i];
      end
      bus.acc_valid_i = 1'b1;
      done    = 1'b0;
      acc_cyc = -1;
      for (int n = 0; n < 40 && !done; n++) begin
         was_ready = bus.acc_ready_o;
         tick();
         if (was_ready) begin
            done    = 1'b1;
            acc_cyc = cyc;
         end
      end
      bus.acc_valid_i = 1'b0;
      if (done) begin
         for (int i = 0; i < NC; i++) q.push_back(model(acc_v[i], bias_v[i], i));
      end else begin
         check("accept_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q.size() != 0 || bus.z_valid_o) && n < 100) begin
         tick();
         n++;
      end
      check("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic set_row(input longint a0, a1, a2, a3,
                          input logic [15:0] b0, b1, b2, b3);
      acc_v[0] = a0; acc_v[1] = a1; acc_v[2] = a2; acc_v[3] = a3;
      bias_v[0] = b0; bias_v[1] = b1; bias_v[2] = b2; bias_v[3] = b3;
   endtask

   // Scoreboard: an output is consumed on every edge where valid && ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.z_valid_o && bus.z_ready_i) begin
         if (q.size() == 0) begin
            check("unexpected_output", {30'd0, bus.z_col_o}, 32'hFFFF_FFFF);
         end else begin
            e = q.pop_front();
            check("z",    32'(bus.z_o),     32'(e.z));
            check("col",  32'(bus.z_col_o), 32'(e.col));
            check("last", 32'(bus.z_last_o), 32'(e.last));
            check("sat",  32'(bus.sat_o),   32'(e.sat));
         end
      end
   end

   initial begin
      int t_a, t_b, t_x, n;
      logic [DW-1:0] held;
      logic [AW-1:0] tmp;

      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.acc_valid_i = 1'b0;
      bus.acc_i  = '0;
      bus.bias_i = '0;
      bus.z_ready_i = 1'b1;

      #12;
      check("rst_acc_ready", 32'(bus.acc_ready_o), 32'd1);
      check("rst_z_valid",   32'(bus.z_valid_o),   32'd0);
      check("rst_z",         32'(bus.z_o),         32'd0);
      check("rst_z_col",     32'(bus.z_col_o),     32'd0);
      check("rst_z_last",    32'(bus.z_last_o),    32'd0);
      check("rst_sat",       32'(bus.sat_o),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle_acc_ready", 32'(bus.acc_ready_o), 32'd1);

      // Basic: 1.5 + 1.0 = 2.5 on column 0, visible right after E1.
      set_row(64'h18000, 64'h10000, -64'h20000, 64'h1234, 16'h0100, 16'h0000, 16'h0010, 16'hFFFF);
      send_row(t_x);
      check("busy_acc_ready", 32'(bus.acc_ready_o), 32'd0);
      tick();
      check("e1_valid", 32'(bus.z_valid_o), 32'd1);
      check("e1_col",   32'(bus.z_col_o),   32'd0);
      check("e1_z",     32'(bus.z_o),       32'h0280);
      wait_drain();

      // Rounding ties and just-below-half.
      set_row(64'h80, 64'h7F, -64'h80, -64'h81, 16'h0, 16'h0, 16'h0, 16'h0);
      send_row(t_x);
      wait_drain();

      // Saturation both ways, bias-driven overflow, and an in-range neighbour.
      set_row(64'd200 <<< 16, -(64'd200 <<< 16), 64'h7F <<< 16, 64'h7F <<< 16,
              16'h0, 16'h0, 16'h7FFF, 16'h0);
      send_row(t_x);
      wait_drain();

      // Exact range edges and one step beyond.
      set_row(64'h7FFF00, 64'h7FFF80, -64'h800000, -64'h800081, 16'h0, 16'h0, 16'h0, 16'h0);
      send_row(t_x);
      wait_drain();

      // Backpressure while column 1 is presented.
      set_row(64'h3_0000, 64'h4_5600, 64'h7_8900, -64'h1_2300, 16'h0001, 16'hFF00, 16'h0020, 16'h0100);
      send_row(t_x);
      n = 0;
      while (!(bus.z_valid_o && bus.z_col_o == 2'd1) && n < 20) begin
         tick();
         n++;
      end
      check("bp_reach_col1", 32'(bus.z_col_o), 32'd1);
      bus.z_ready_i = 1'b0;
      held = bus.z_o;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_valid",     32'(bus.z_valid_o),   32'd1);
         check("bp_col",       32'(bus.z_col_o),     32'd1);
         check("bp_z",         32'(bus.z_o),         32'(held));
         check("bp_acc_ready", 32'(bus.acc_ready_o), 32'd0);
      end
      bus.z_ready_i = 1'b1;
      tick();
      check("bp_resume_col", 32'(bus.z_col_o), 32'd2);
      wait_drain();

      // Back-to-back rows with acc_valid held.
      set_row(64'h1_0000, 64'h2_0000, 64'h3_0000, 64'h4_0000, 16'h0, 16'h0, 16'h0, 16'h0);
      send_row(t_a);
      set_row(-64'h1_0000, -64'h2_0000, 64'h5_0080, 64'h6_0000, 16'h0002, 16'h0, 16'h0, 16'h8000);
      send_row(t_b);
      check("b2b_gap", 32'(t_b - t_a), 32'(NC + 1));
      wait_drain();

      // A few random rows over a spread of magnitudes.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NC; i++) begin
            tmp = 40'({$urandom(), $urandom()});
            acc_v[i]  = longint'($signed(tmp)) >>> $urandom_range(0, 30);
            bias_v[i] = 16'($urandom());
         end
         send_row(t_x);
         wait_drain();
      end

      // Reset mid-burst after column 1 has been consumed.
      set_row(64'h1_0000, 64'h2_0000, 64'h3_0000, 64'h4_0000, 16'h0, 16'h0, 16'h0, 16'h0);
      send_row(t_x);
      n = 0;
      while (q.size() != 2 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("rst_mid_popped", 32'(q.size()), 32'd2);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(bus.z_valid_o), 32'd0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_mid_ready", 32'(bus.acc_ready_o), 32'd1);
      check("rst_mid_idle",  32'(bus.z_valid_o),   32'd0);
      set_row(64'h8_0000, 64'h9_0000, 64'hA_0000, 64'hB_0000, 16'h0, 16'h0, 16'h0, 16'h0);
      send_row(t_x);
      tick();
      check("rst_fresh_col0", 32'(bus.z_col_o), 32'd0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
